// File: rtl/spi_slave_core_pkg.sv
// -----------------------------------------------------------------------------
// spi_slave_core_pkg
// Shared definitions for the SPI slave endpoint:
//   - FSM state encoding (IDLE / ACTIVE)
//   - bit positions of cpol/cpha inside the latched 2-bit mode register
//   - default byte shifted out on miso when the TX buffer is empty
//   - helpers that turn raw sck rise/fall pulses into sample/shift strobes
// -----------------------------------------------------------------------------
package spi_slave_core_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam int MODE_CPHA_BIT = 0;
    localparam int MODE_CPOL_BIT = 1;

    localparam logic [7:0] DEFAULT_FILL_BYTE = 8'hFF;

    // Leading edge is rising for cpol=0 and falling for cpol=1.
    // Data is sampled on the leading edge when cpha=0, else on the trailing one.
    function automatic logic sample_edge(input logic cpol, input logic cpha,
                                         input logic rise, input logic fall);
        logic lead;
        logic trail;
        lead  = cpol ? fall : rise;
        trail = cpol ? rise : fall;
        return cpha ? trail : lead;
    endfunction

    // The shift edge is always the edge that is not the sample edge.
    function automatic logic shift_edge(input logic cpol, input logic cpha,
                                        input logic rise, input logic fall);
        logic lead;
        logic trail;
        lead  = cpol ? fall : rise;
        trail = cpol ? rise : fall;
        return cpha ? lead : trail;
    endfunction

endpackage

// File: rtl/spi_slave_core_if.sv
// -----------------------------------------------------------------------------
// spi_slave_core_if
// Bundles every non-clock/reset signal of the SPI slave endpoint.
//   SPI pins  : sck_i, ssn_i, mosi_i (in), miso_o, miso_oe_o (out)
//   Mode      : cpol_i, cpha_i (sampled by the slave only while idle)
//   RX port   : rx_data_o, rx_valid_o, rx_ready_i, rx_ovf_o
//   TX port   : tx_data_i, tx_valid_i, tx_ready_o, tx_udf_o
//   Status    : busy_o (slave FSM is ACTIVE)
// Handshakes: a transfer happens on a clk_i edge where valid & ready are both
// high. RX: the slave holds rx_data_o/rx_valid_o until accepted. TX: the
// producer holds tx_data_i/tx_valid_i until tx_ready_o is seen high.
// Modports: slave = the endpoint, master = whoever drives pins and ports.
// -----------------------------------------------------------------------------
interface spi_slave_core_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  cpol_i;
    logic                  cpha_i;
    logic                  sck_i;
    logic                  ssn_i;
    logic                  mosi_i;
    logic                  miso_o;
    logic                  miso_oe_o;
    logic [DATA_WIDTH-1:0] rx_data_o;
    logic                  rx_valid_o;
    logic                  rx_ready_i;
    logic                  rx_ovf_o;
    logic [DATA_WIDTH-1:0] tx_data_i;
    logic                  tx_valid_i;
    logic                  tx_ready_o;
    logic                  tx_udf_o;
    logic                  busy_o;

    modport slave (
        input  cpol_i, cpha_i, sck_i, ssn_i, mosi_i,
        input  rx_ready_i, tx_data_i, tx_valid_i,
        output miso_o, miso_oe_o, rx_data_o, rx_valid_o, rx_ovf_o,
        output tx_ready_o, tx_udf_o, busy_o
    );

    modport master (
        output cpol_i, cpha_i, sck_i, ssn_i, mosi_i,
        output rx_ready_i, tx_data_i, tx_valid_i,
        input  miso_o, miso_oe_o, rx_data_o, rx_valid_o, rx_ovf_o,
        input  tx_ready_o, tx_udf_o, busy_o
    );

endinterface

// File: rtl/spi_slave_core_sync.sv
// -----------------------------------------------------------------------------
// spi_slave_core_sync
// STAGES-deep single-bit synchroniser for an asynchronous input pin.
//   i_clk  : destination clock
//   i_rst  : asynchronous reset, active-high; all stages load RESET_VAL
//   i_d    : asynchronous input
//   o_q    : synchronised output (last stage)
// -----------------------------------------------------------------------------
module spi_slave_core_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_slave_core.sv
// -----------------------------------------------------------------------------
// spi_slave_core
// SPI slave endpoint, oversampling sck/ssn/mosi in the clk_i domain.
// Supports all four CPOL/CPHA modes, MSB first, DATA_WIDTH-bit frames.
//   clk_i, rst_i : system clock (>= 4x sck), asynchronous active-high reset
//   bus (slave)  : SPI pins, mode inputs, RX valid/ready port with overflow
//                  pulse, TX 1-deep buffer with underflow pulse, busy status
// Received frames go to a single holding register (overwritten on overflow).
// Frames are transmitted from a 1-deep TX buffer, or FILL_BYTE when empty.
// DATA_WIDTH must be at least 3.
// -----------------------------------------------------------------------------
module spi_slave_core
    import spi_slave_core_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] FILL_BYTE   = DATA_WIDTH'(DEFAULT_FILL_BYTE)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    spi_slave_core_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    // Synchronised pins
    logic w_sck_s;
    logic w_ssn_s;
    logic w_mosi_s;

    spi_slave_core_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   (bus.sck_i),
        .o_q   (w_sck_s)
    );

    // ssn resets to "deselected" so reset release never looks like a select
    // unless the pin really is low.
    spi_slave_core_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ssn (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   (bus.ssn_i),
        .o_q   (w_ssn_s)
    );

    spi_slave_core_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   (bus.mosi_i),
        .o_q   (w_mosi_s)
    );

    // Registers
    state_t                r_state;
    logic [1:0]            r_mode;
    logic                  r_sck_d;
    logic                  r_ssn_d;
    logic                  r_rise;
    logic                  r_fall;
    logic                  r_mosi_d;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-2:0] r_rx_sr;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_rx_ovf;
    logic [DATA_WIDTH-1:0] r_tx_sr;
    logic [DATA_WIDTH-1:0] r_tx_buf;
    logic                  r_tx_full;
    logic                  r_tx_udf;

    // Combinational
    state_t                w_state_nxt;
    logic                  w_busy;
    logic                  w_miso_oe;
    logic                  w_cpol;
    logic                  w_cpha;
    logic                  w_ssn_fall;
    logic                  w_sel;
    logic                  w_sample;
    logic                  w_shift;
    logic                  w_enter;
    logic                  w_leave;
    logic                  w_complete;
    logic                  w_reload;
    logic                  w_tx_wr;
    logic [DATA_WIDTH-1:0] w_rx_byte;

    assign w_cpol     = r_mode[MODE_CPOL_BIT];
    assign w_cpha     = r_mode[MODE_CPHA_BIT];
    assign w_ssn_fall = r_ssn_d & ~w_ssn_s;
    assign w_sel      = (r_state == ST_ACTIVE) & ~w_ssn_s;

    // r_rise/r_fall are one cycle behind w_sck_s; r_mosi_d is delayed by the
    // same amount so the sampled bit lines up with its sck edge.
    assign w_sample   = w_sel & sample_edge(w_cpol, w_cpha, r_rise, r_fall);
    assign w_shift    = w_sel & shift_edge(w_cpol, w_cpha, r_rise, r_fall);
    assign w_enter    = (r_state == ST_IDLE) & w_ssn_fall;
    assign w_leave    = (r_state == ST_ACTIVE) & w_ssn_s;
    assign w_complete = w_sample & (r_bit_cnt == LAST_BIT);
    assign w_rx_byte  = {r_rx_sr, r_mosi_d};

    // A shift edge with bit_cnt==0 is the frame boundary in both phases:
    // cpha=1 it is the first leading edge of a frame, cpha=0 it is the
    // trailing edge after the last sample. cpha=0 also needs the MSB on miso
    // before the first sck edge, hence the extra load on select.
    assign w_reload   = (w_enter & ~w_cpha) | (w_shift & (r_bit_cnt == '0));
    assign w_tx_wr    = bus.tx_valid_i & ~r_tx_full;

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_miso_oe   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ssn_fall) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                w_busy    = 1'b1;
                w_miso_oe = 1'b1;
                if (w_ssn_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mode     <= '0;
            r_sck_d    <= 1'b0;
            r_ssn_d    <= 1'b1;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_mosi_d   <= 1'b0;
            r_bit_cnt  <= '0;
            r_rx_sr    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ovf   <= 1'b0;
            r_tx_sr    <= '0;
            r_tx_buf   <= '0;
            r_tx_full  <= 1'b0;
            r_tx_udf   <= 1'b0;
        end else begin
            r_sck_d  <= w_sck_s;
            r_ssn_d  <= w_ssn_s;
            r_rise   <= w_sck_s & ~r_sck_d;
            r_fall   <= ~w_sck_s & r_sck_d;
            r_mosi_d <= w_mosi_s;
            r_rx_ovf <= 1'b0;
            r_tx_udf <= 1'b0;

            // Mode may only change between selects.
            if (r_state == ST_IDLE) begin
                r_mode[MODE_CPOL_BIT] <= bus.cpol_i;
                r_mode[MODE_CPHA_BIT] <= bus.cpha_i;
            end

            // Bit counter and receive shift register; a deselect throws away
            // any partial frame.
            if (w_enter || w_leave) begin
                r_bit_cnt <= '0;
                r_rx_sr   <= '0;
            end else if (w_sample) begin
                r_rx_sr   <= w_rx_byte[DATA_WIDTH-2:0];
                r_bit_cnt <= w_complete ? '0 : r_bit_cnt + CNT_W'(1);
            end

            // RX holding register: a new byte wins over a same-cycle accept.
            if (w_complete) begin
                r_rx_data  <= w_rx_byte;
                r_rx_valid <= 1'b1;
                r_rx_ovf   <= r_rx_valid & ~bus.rx_ready_i;
            end else if (r_rx_valid && bus.rx_ready_i) begin
                r_rx_valid <= 1'b0;
            end

            // Transmit shift register
            if (w_reload) begin
                if (r_tx_full) begin
                    r_tx_sr <= r_tx_buf;
                end else begin
                    r_tx_sr  <= FILL_BYTE;
                    r_tx_udf <= 1'b1;
                end
            end else if (w_enter) begin
                // cpha=1: nothing is presented until the first shift edge.
                r_tx_sr <= '0;
            end else if (w_shift) begin
                r_tx_sr <= {r_tx_sr[DATA_WIDTH-2:0], 1'b0};
            end

            // TX buffer: writes only land while empty, so a same-cycle reload
            // sees the old (empty) state and the new byte waits for the next.
            if (w_tx_wr) begin
                r_tx_buf  <= bus.tx_data_i;
                r_tx_full <= 1'b1;
            end else if (w_reload && r_tx_full) begin
                r_tx_full <= 1'b0;
            end
        end
    end

    assign bus.miso_o     = (r_state == ST_ACTIVE) ? r_tx_sr[DATA_WIDTH-1] : 1'b0;
    assign bus.miso_oe_o  = w_miso_oe;
    assign bus.busy_o     = w_busy;
    assign bus.rx_data_o  = r_rx_data;
    assign bus.rx_valid_o = r_rx_valid;
    assign bus.rx_ovf_o   = r_rx_ovf;
    assign bus.tx_ready_o = ~r_tx_full;
    assign bus.tx_udf_o   = r_tx_udf;

endmodule
